// File: rtl/usb2_ep_ring_if.sv
// usb2_ep_ring_if
// Bundles the endpoint-ring buses: the writer side (buf_in_*), the reader
// side (buf_out_*), status/error outputs and the data-toggle controls.
//   slave  : view taken by the ring itself (usb2_ep_ring)
//   master : view taken by the protocol/application logic driving the ring
// Parameters NBUF/BUF_AW/DW must match those of the attached ring.
interface usb2_ep_ring_if #(
    parameter int NBUF   = 4,
    parameter int BUF_AW = 9,
    parameter int DW     = 8
);
    localparam int NW = $clog2(NBUF);

    // writer side
    logic [BUF_AW-1:0] buf_in_addr;
    logic [DW-1:0]     buf_in_data;
    logic              buf_in_wren;
    logic              buf_in_ready;
    logic              buf_in_commit;
    logic [BUF_AW:0]   buf_in_commit_len;
    logic              buf_in_commit_ack;
    // reader side
    logic [BUF_AW-1:0] buf_out_addr;
    logic [DW-1:0]     buf_out_q;
    logic [BUF_AW:0]   buf_out_len;
    logic              buf_out_hasdata;
    logic              buf_out_arm;
    logic              buf_out_arm_ack;
    // status
    logic [NW:0]       fill_count;
    logic              err_overrun;
    logic              err_underrun;
    // data toggle
    logic [1:0]        mode;
    logic              data_toggle_act;
    logic              data_toggle_rst;
    logic [1:0]        data_toggle;

    modport slave (
        input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
        input  buf_out_addr, buf_out_arm,
        input  mode, data_toggle_act, data_toggle_rst,
        output buf_in_ready, buf_in_commit_ack,
        output buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack,
        output fill_count, err_overrun, err_underrun, data_toggle
    );

    modport master (
        output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
        output buf_out_addr, buf_out_arm,
        output mode, data_toggle_act, data_toggle_rst,
        input  buf_in_ready, buf_in_commit_ack,
        input  buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack,
        input  fill_count, err_overrun, err_underrun, data_toggle
    );
endinterface

// File: rtl/usb2_ep_ring.sv
// usb2_ep_ring
// Multi-buffer USB 2.0 endpoint store: a ring of NBUF packet buffers of
// 2^BUF_AW words each, held in one inferred RAM. The writer fills the buffer
// at wp and commits it with a length; the reader drains the buffer at rp and
// releases it with arm. Tracks occupancy, per-buffer length and the
// mode-aware data toggle (DATA0/DATA1, plus DATA2 for high-bandwidth isoch).
//
// Ports:
//   phy_clk  - sole clock, rising edge
//   reset    - synchronous, active-high
//   flush    - clears all buffers (only when USB2_EP_RING_FLUSH_EN is defined)
//   bus      - usb2_ep_ring_if.slave: writer, reader, status and toggle signals
//
// Build option: define USB2_EP_RING_FLUSH_EN to add the flush port/logic.
module usb2_ep_ring #(
    parameter int NBUF   = 4,
    parameter int BUF_AW = 9,
    parameter int DW     = 8
) (
    input  logic phy_clk,
    input  logic reset,
`ifdef USB2_EP_RING_FLUSH_EN
    input  logic flush,
`endif
    usb2_ep_ring_if.slave bus
);
    localparam int NW     = $clog2(NBUF);
    localparam int DEPTH  = NBUF << BUF_AW;
    localparam logic [NW:0]     CNT_FULL = (NW+1)'(NBUF);
    localparam logic [BUF_AW:0] LEN_MAX  = (BUF_AW+1)'(1 << BUF_AW);

    logic [NW-1:0]   wp_reg, rp_reg;
    logic [NW:0]     count_reg, count_next;
    logic [BUF_AW:0] len_reg [NBUF];
    logic [1:0]      toggle_reg, toggle_next;
    logic            commit_ack_reg, arm_ack_reg;
    logic            err_overrun_reg, err_underrun_reg;
    logic [DW-1:0]   q_reg;
    logic [DW-1:0]   mem [DEPTH];

    logic            flush_act;
    logic            buf_full, buf_empty;
    logic            commit_ok, commit_rej, arm_ok, arm_rej;
    logic [BUF_AW:0] len_clamped;
    logic [NBUF-1:0] len_we;

`ifdef USB2_EP_RING_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    assign buf_full  = (count_reg == CNT_FULL);
    assign buf_empty = (count_reg == '0);

    // Acceptance is judged on the pre-cycle count, so a commit into a full
    // ring is rejected even when an arm frees a buffer in the same cycle.
    // A flush swallows both requests silently.
    assign commit_ok  = bus.buf_in_commit && !buf_full  && !flush_act;
    assign commit_rej = bus.buf_in_commit &&  buf_full  && !flush_act;
    assign arm_ok     = bus.buf_out_arm   && !buf_empty && !flush_act;
    assign arm_rej    = bus.buf_out_arm   &&  buf_empty && !flush_act;

    assign len_clamped = (bus.buf_in_commit_len > LEN_MAX) ? LEN_MAX : bus.buf_in_commit_len;

    genvar gi;
    generate
        for (gi = 0; gi < NBUF; gi++) begin : g_len_we
            assign len_we[gi] = commit_ok && (wp_reg == NW'(gi));
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({commit_ok, arm_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Isoch high-bandwidth cycles DATA0->DATA1->DATA2; other modes alternate.
    // An out-of-range value (3, or 2 left over after a mode change) recovers to DATA0.
    always_comb begin
        toggle_next = toggle_reg;
        if (bus.data_toggle_rst) begin
            toggle_next = 2'd0;
        end else if (bus.data_toggle_act) begin
            if (bus.mode == 2'd1) begin
                case (toggle_reg)
                    2'd0:    toggle_next = 2'd1;
                    2'd1:    toggle_next = 2'd2;
                    default: toggle_next = 2'd0;
                endcase
            end else begin
                toggle_next = (toggle_reg == 2'd0) ? 2'd1 : 2'd0;
            end
        end
    end

    always_ff @(posedge phy_clk) begin
        if (reset) begin
            wp_reg           <= '0;
            rp_reg           <= '0;
            count_reg        <= '0;
            for (int i = 0; i < NBUF; i++) len_reg[i] <= '0;
            toggle_reg       <= 2'd0;
            commit_ack_reg   <= 1'b0;
            arm_ack_reg      <= 1'b0;
            err_overrun_reg  <= 1'b0;
            err_underrun_reg <= 1'b0;
        end else begin
            if (flush_act) begin
                wp_reg    <= '0;
                rp_reg    <= '0;
                count_reg <= '0;
                for (int i = 0; i < NBUF; i++) len_reg[i] <= '0;
            end else begin
                if (commit_ok) wp_reg <= wp_reg + 1'b1;
                if (arm_ok)    rp_reg <= rp_reg + 1'b1;
                count_reg <= count_next;
                for (int i = 0; i < NBUF; i++) begin
                    if (len_we[i]) len_reg[i] <= len_clamped;
                end
            end
            toggle_reg       <= toggle_next;
            commit_ack_reg   <= commit_ok;
            arm_ack_reg      <= arm_ok;
            err_overrun_reg  <= commit_rej;
            err_underrun_reg <= arm_rej;
        end
    end

    // Packet RAM: no reset so it maps to block RAM. The read is registered
    // and sees the pre-write contents on a same-address collision.
    always_ff @(posedge phy_clk) begin
        if (bus.buf_in_wren && !buf_full) begin
            mem[{wp_reg, bus.buf_in_addr}] <= bus.buf_in_data;
        end
        q_reg <= mem[{rp_reg, bus.buf_out_addr}];
    end

    assign bus.buf_in_ready      = !buf_full;
    assign bus.buf_in_commit_ack = commit_ack_reg;
    assign bus.buf_out_q         = q_reg;
    assign bus.buf_out_len       = len_reg[rp_reg];
    assign bus.buf_out_hasdata   = !buf_empty;
    assign bus.buf_out_arm_ack   = arm_ack_reg;
    assign bus.fill_count        = count_reg;
    assign bus.err_overrun       = err_overrun_reg;
    assign bus.err_underrun      = err_underrun_reg;
    assign bus.data_toggle       = toggle_reg;
endmodule

// File: doc/usb2_ep_ring.md
# usb2_ep_ring

Parametrised multi-buffer USB 2.0 endpoint store: a ring of NBUF equal-sized packet buffers in one inferred RAM, filled by the protocol/application writer and drained by the reader, with per-buffer length, occupancy count and mode-aware data toggle. It succeeds the fixed two-buffer endpoint and sits between the USB 2.0 protocol layer and the application-side endpoint interface. Everything runs in one clock domain, so there are no commit/arm synchronizers and the handshakes are single-cycle.

## Interface
Parameters:
- NBUF, 4: number of packet buffers; power of 2, 2..16. NW = log2(NBUF).
- BUF_AW, 9: buffer address width; each buffer holds 2^BUF_AW words.
- DW, 8: data word width.

Ports:
- phy_clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- buf_in_addr  in  BUF_AW  write offset within the current write buffer.
- buf_in_data  in  DW  write data.
- buf_in_wren  in  1  write strobe.
- buf_in_ready  out  1  a free buffer is available (count < NBUF).
- buf_in_commit  in  1  one-cycle pulse: close the current write buffer.
- buf_in_commit_len  in  BUF_AW+1  valid word count of the committed buffer.
- buf_in_commit_ack  out  1  one-cycle pulse: commit accepted.
- buf_out_addr  in  BUF_AW  read offset within the current read buffer.
- buf_out_q  out  DW  read data, 1-cycle latency.
- buf_out_len  out  BUF_AW+1  length of the current read buffer.
- buf_out_hasdata  out  1  count > 0.
- buf_out_arm  in  1  one-cycle pulse: release the current read buffer.
- buf_out_arm_ack  out  1  one-cycle pulse: release accepted.
- fill_count  out  NW+1  occupied buffers, 0..NBUF.
- err_overrun  out  1  one-cycle pulse: commit while full.
- err_underrun  out  1  one-cycle pulse: arm while empty.
- mode  in  2  0 control, 1 isoch, 2 bulk, 3 interrupt.
- data_toggle_act  in  1  advance the toggle.
- data_toggle_rst  in  1  force DATA0.
- data_toggle  out  2  current PID sequence: 0 DATA0, 1 DATA1, 2 DATA2.
- flush  in  1  present only with USB2_EP_RING_FLUSH_EN.

## Operation
- State registers: wp, rp (NW bits, wrap modulo NBUF), count (NW+1 bits), len[NBUF] (BUF_AW+1 bits each), data_toggle.
- RAM depth is NBUF·2^BUF_AW.
  - Write address {wp, buf_in_addr}; read address {rp, buf_out_addr}.
  - A write happens only when buf_in_wren && buf_in_ready; wren while full is dropped.
- Commit accepted when buf_in_commit && count < NBUF:
  - len[wp] <= min(buf_in_commit_len, 2^BUF_AW); lengths above 2^BUF_AW are clamped.
  - wp <= wp+1, count +1, buf_in_commit_ack=1 next cycle.
- Commit while full: no state change, no ack, err_overrun=1 next cycle.
- Arm accepted when buf_out_arm && count > 0: rp <= rp+1, count −1, buf_out_arm_ack=1 next cycle.
- Arm while empty: no state change, no ack, err_underrun=1 next cycle.
- Simultaneous accepted commit and arm: both pointers advance and count is unchanged.
  - Commit when full plus arm in the same cycle: the arm is accepted, the commit is rejected with overrun (acceptance is judged on pre-cycle count).
- buf_out_len = len[rp]; buf_out_hasdata = (count != 0); buf_in_ready = (count != NBUF); fill_count = count.
- Data toggle:
  - data_toggle_rst has priority over data_toggle_act.
  - mode 0/2/3: 0→1→0.
  - mode 1 (isoch high-bandwidth): 0→1→2→0.
  - A toggle value of 3 is never produced; if reached, the next act yields 0.
- Reset: wp=rp=count=0, all len=0, data_toggle=0, all acks and err pulses 0, buf_in_ready=1, buf_out_hasdata=0.
  - Reset mid-operation discards all buffers; RAM contents are not cleared.

## Timing
- Commit/arm sampled at edge T; pointers, count, len, ready, hasdata and the ack/err pulses are all valid after T+1. Pulses last exactly 1 cycle.
- Back-to-back commits on consecutive cycles are each accepted while space remains.
- buf_out_q reflects the address presented one edge earlier.
- A same-cycle read and write to the same RAM word returns the old data.
- data_toggle updates one cycle after act/rst.

## Configuration
- USB2_EP_RING_FLUSH_EN defined:
  - The flush port exists. flush=1 at edge T sets wp=rp=count=0 and all len=0 after T+1; data_toggle is unchanged.
  - Any commit or arm in the same cycle is discarded with no ack and no err pulse. Flush has lower priority than reset.
- Macro undefined: the port is absent and there is no flush logic.

## Test plan
- Reset, NBUF=4: write 64 bytes 0x00..0x3F, commit len=64 → ack 1 cycle, fill_count=1, hasdata=1, buf_out_len=64; reading offsets 0..63 returns 0x00..0x3F.
- Commit 4 buffers → ready=0; 5th commit → no ack, err_overrun=1, fill_count stays 4; wren while full leaves RAM unchanged.
- With fill_count=2, commit and arm in the same cycle → both acks, fill_count=2, wp and rp each +1. Arm at fill_count=0 → err_underrun only.
- Commit len=600 with BUF_AW=9 → buf_out_len=512.
- Toggle: mode=2, 3 acts → 1,0,1. mode=1, 4 acts → 1,2,0,1. rst and act together → 0.
- With USB2_EP_RING_FLUSH_EN: 3 buffers filled, then flush plus a commit in the same cycle → fill_count=0, no ack, ready=1, toggle value kept.
